// File: rtl/pipeline_skid_reg.sv
// Two-entry handshaked stage register (main + skid) with registered in_ready.
// Synchronous active-low reset and synchronous flush.
module pipeline_skid_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pipeline_out,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             take;

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    unique case (1'b1)
      state_q == ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      state_q == TWO: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign pipeline_out = main_q;
  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Directed bench for pipeline_skid_reg: reset, streaming,
// backpressure, drain, flush and reset mid-operation.
module tb_pipeline_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pipeline_out;
  logic [1:0]  occupancy;

  int total = 0;
  int bad = 0;

  pipeline_skid_reg #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pipeline_out (pipeline_out),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v,
                           input logic r, input logic [1:0] o);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, o});
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    out_ready = 1'b0;
    tick();
    tick();
    chk_state("reset", 1'b0, 1'b1, 2'd0);
    chk("reset.pout", {16'd0, pipeline_out}, 32'h0);

    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    chk_state("idle", 1'b0, 1'b1, 2'd0);

    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 16'(i);
      tick();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
      chk($sformatf("stream%0d.pout", i), {16'd0, pipeline_out}, i);
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream_end", 1'b0, 1'b1, 2'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hA5A5;
    tick();
    chk_state("bp_one", 1'b1, 1'b1, 2'd1);
    in_data = 16'h5A5A;
    tick();
    chk_state("bp_two", 1'b1, 1'b0, 2'd2);
    chk("bp_two.pout", {16'd0, pipeline_out}, 32'hA5A5);
    in_data = 16'hC3C3;
    tick();
    chk_state("bp_full", 1'b1, 1'b0, 2'd2);
    chk("bp_full.pout", {16'd0, pipeline_out}, 32'hA5A5);
    out_ready = 1'b1;
    tick();
    chk("bp_out2.pout", {16'd0, pipeline_out}, 32'h5A5A);
    chk_state("bp_out2", 1'b1, 1'b1, 2'd1);
    tick();
    chk("bp_out3.pout", {16'd0, pipeline_out}, 32'hC3C3);
    chk_state("bp_out3", 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_state("bp_drain", 1'b0, 1'b1, 2'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1234;
    tick();
    chk_state("drain_one", 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_state("drain_empty", 1'b0, 1'b1, 2'd0);
    chk("drain_empty.pout", {16'd0, pipeline_out}, 32'h1234);
    tick();
    chk_state("underflow", 1'b0, 1'b1, 2'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    chk_state("fl_two", 1'b1, 1'b0, 2'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    in_data = 16'h3333;
    tick();
    chk_state("flush", 1'b0, 1'b1, 2'd0);
    chk("flush.pout", {16'd0, pipeline_out}, 32'h1111);
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_state("flush_hold", 1'b0, 1'b1, 2'd0);
    in_valid = 1'b1;
    in_data = 16'h4444;
    tick();
    chk_state("post_flush", 1'b1, 1'b1, 2'd1);
    chk("post_flush.pout", {16'd0, pipeline_out}, 32'h4444);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_state("post_flush_drain", 1'b0, 1'b1, 2'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h7777;
    tick();
    in_data = 16'h8888;
    tick();
    chk_state("rst_two", 1'b1, 1'b0, 2'd2);
    reset = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_state("rst_mid", 1'b0, 1'b1, 2'd0);
    chk("rst_mid.pout", {16'd0, pipeline_out}, 32'h0);
    reset = 1'b1;
    flush = 1'b0;
    in_data = 16'hBEEF;
    tick();
    chk_state("beef", 1'b1, 1'b1, 2'd1);
    chk("beef.pout", {16'd0, pipeline_out}, 32'hBEEF);
    in_valid = 1'b0;
    tick();
    chk_state("beef_drain", 1'b0, 1'b1, 2'd0);
    chk("beef_drain.pout", {16'd0, pipeline_out}, 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
